// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the two-master ROM read arbiter.
// Owner IDs tag in-flight reads; RD_LATENCY is issue-to-rvalid cycles.
package rom_arbiter_pkg;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    localparam int RD_LATENCY = 2;

    typedef struct packed {
        logic   vld;
        owner_e owner;
    } flight_t;

    // Winner when both masters request in the same cycle.
    function automatic owner_e contend_winner(
        input owner_e last,
        input logic   rr
    );
        if (rr && last == OWN_M0) begin
            return OWN_M1;
        end
        return OWN_M0;
    endfunction

endpackage

// File: rtl/rom_arbiter.sv
// Two-master arbiter in front of a synchronous ROM with a fixed
// two-cycle read latency and per-master registered read data.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    output logic                  m0_ack,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    output logic                  m1_ack,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  rom_cs,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    localparam logic RR_EN = (ROUND_ROBIN != 0);

    owner_e  last_grant;
    owner_e  win;
    owner_e  issue_owner;
    flight_t s1;

    always_comb begin
        win    = contend_winner(last_grant, RR_EN);
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        // Acks are gated by reset so nothing issues while it is held.
        if (rst_n) begin
            if (m0_req && m1_req) begin
                m0_ack = (win == OWN_M0);
                m1_ack = (win == OWN_M1);
            end else begin
                m0_ack = m0_req;
                m1_ack = m1_req;
            end
        end
    end

    assign rom_cs      = m0_ack | m1_ack;
    assign issue_owner = m1_ack ? OWN_M1 : OWN_M0;

    always_comb begin
        rom_addr = '0;
        if (m0_ack) begin
            rom_addr = m0_addr;
        end else if (m1_ack) begin
            rom_addr = m1_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWN_M1;
            s1         <= '0;
        end else begin
            if (rom_cs) begin
                last_grant <= issue_owner;
            end
            s1.vld   <= rom_cs;
            s1.owner <= issue_owner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= s1.vld && (s1.owner == OWN_M0);
            m1_rvalid <= s1.vld && (s1.owner == OWN_M1);
            if (s1.vld && s1.owner == OWN_M0) begin
                m0_rdata <= rom_data;
            end
            if (s1.vld && s1.owner == OWN_M1) begin
                m1_rdata <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench: one round-robin and one fixed-priority arbiter
// share stimulus; each drives its own behavioural ROM.
module tb_rom_arbiter;
    import rom_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req, m1_req;
    logic [AW-1:0] m0_addr, m1_addr;

    logic [1:0]    m0_ack, m1_ack, m0_rvalid, m1_rvalid, rom_cs;
    logic [DW-1:0] m0_rdata [2];
    logic [DW-1:0] m1_rdata [2];
    logic [DW-1:0] rom_data [2];
    logic [AW-1:0] rom_addr [2];

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct packed {
        int unsigned        cyc;
        logic [1:0]         a0;
        logic [1:0]         a1;
        logic [1:0][AW-1:0] addr;
    } ack_t;

    typedef struct packed {
        int unsigned cyc;
        logic        inst;
        owner_e      owner;
        logic [DW-1:0] data;
    } rsp_t;

    ack_t   ackq[$];
    rsp_t   rspq[$];
    owner_e last [2];

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        logic [7:0] hi;
        hi = a[15:8] * 8'd37;
        return a[7:0] ^ hi ^ 8'hB5;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        rom_arbiter #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .ROUND_ROBIN(k == 0 ? 1 : 0)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .m0_req   (m0_req),
            .m0_addr  (m0_addr),
            .m0_ack   (m0_ack[k]),
            .m0_rvalid(m0_rvalid[k]),
            .m0_rdata (m0_rdata[k]),
            .m1_req   (m1_req),
            .m1_addr  (m1_addr),
            .m1_ack   (m1_ack[k]),
            .m1_rvalid(m1_rvalid[k]),
            .m1_rdata (m1_rdata[k]),
            .rom_cs   (rom_cs[k]),
            .rom_addr (rom_addr[k]),
            .rom_data (rom_data[k])
        );
    end

    // Synchronous ROM: data valid the cycle after chip select.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rom_data[k] <= rom_cs[k] ? rom_word(rom_addr[k]) : 8'hEE;
        end
    end

    task automatic check(input string nm, input int k,
                         input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[inst %0d] cyc %0d: got %0h expected %0h",
                     nm, k, cyc, got, exp);
        end
    endtask

    // Drive one cycle and push the expected outcome for both instances.
    task automatic drive(input logic r0, input logic [AW-1:0] a0,
                         input logic r1, input logic [AW-1:0] a1,
                         input logic rn);
        ack_t   e;
        owner_e g;
        logic   hit;
        @(posedge clk);
        #1;
        m0_req  = r0;
        m0_addr = a0;
        m1_req  = r1;
        m1_addr = a1;
        rst_n   = rn;
        e       = '0;
        e.cyc   = cyc;
        if (!rn) begin
            last[0] = OWN_M1;
            last[1] = OWN_M1;
            rspq.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                hit = 1'b1;
                g   = OWN_M0;
                if (r0 && r1) begin
                    g = (k == 0 && last[k] == OWN_M0) ? OWN_M1 : OWN_M0;
                end else if (r1) begin
                    g = OWN_M1;
                end else if (!r0) begin
                    hit = 1'b0;
                end
                if (hit) begin
                    last[k] = g;
                    if (g == OWN_M0) begin
                        e.a0[k]   = 1'b1;
                        e.addr[k] = a0;
                    end else begin
                        e.a1[k]   = 1'b1;
                        e.addr[k] = a1;
                    end
                    rspq.push_back('{cyc: cyc + RD_LATENCY, inst: 1'(k),
                                     owner: g, data: rom_word(e.addr[k])});
                end
            end
        end
        ackq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    logic [DW-1:0] exp_rd0 [2];
    logic [DW-1:0] exp_rd1 [2];

    always @(negedge clk) begin
        ack_t          e;
        rsp_t          r;
        logic [1:0]    ev0, ev1;
        logic [DW-1:0] ed0 [2];
        logic [DW-1:0] ed1 [2];
        if (ackq.size() != 0 && ackq[0].cyc <= cyc) begin
            e = ackq.pop_front();
            check("ack_cycle", 0, e.cyc, cyc);
            for (int k = 0; k < 2; k++) begin
                check("m0_ack", k, 32'(m0_ack[k]), 32'(e.a0[k]));
                check("m1_ack", k, 32'(m1_ack[k]), 32'(e.a1[k]));
                check("rom_cs", k, 32'(rom_cs[k]), 32'(e.a0[k] | e.a1[k]));
                check("rom_addr", k, 32'(rom_addr[k]), 32'(e.addr[k]));
            end
        end
        ev0 = '0;
        ev1 = '0;
        for (int k = 0; k < 2; k++) begin
            ed0[k] = '0;
            ed1[k] = '0;
        end
        while (rspq.size() != 0 && rspq[0].cyc <= cyc) begin
            r = rspq.pop_front();
            check("rsp_cycle", 32'(r.inst), r.cyc, cyc);
            if (r.owner == OWN_M0) begin
                ev0[r.inst] = 1'b1;
                ed0[r.inst] = r.data;
            end else begin
                ev1[r.inst] = 1'b1;
                ed1[r.inst] = r.data;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                exp_rd0[k] = '0;
                exp_rd1[k] = '0;
            end
            if (ev0[k]) exp_rd0[k] = ed0[k];
            if (ev1[k]) exp_rd1[k] = ed1[k];
            if (ackq.size() != 0 || cyc > 2) begin
                check("m0_rvalid", k, 32'(m0_rvalid[k]), 32'(ev0[k]));
                check("m1_rvalid", k, 32'(m1_rvalid[k]), 32'(ev1[k]));
                check("m0_rdata", k, 32'(m0_rdata[k]), 32'(exp_rd0[k]));
                check("m1_rdata", k, 32'(m1_rdata[k]), 32'(exp_rd1[k]));
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            exp_rd0[k] = '0;
            exp_rd1[k] = '0;
            last[k]    = OWN_M1;
        end
        m0_req  = 1'b1;
        m1_req  = 1'b1;
        m0_addr = 16'h0001;
        m1_addr = 16'h0002;
        // Reset held with both requesting: no acks may appear.
        repeat (3) drive(1'b1, 16'h0001, 1'b1, 16'h0002, 1'b0);
        idle(1);
        // Solo read of 0x0010 (ROM word 0xA5).
        drive(1'b1, 16'h0010, 1'b0, '0, 1'b1);
        idle(3);
        // Continuous contention, then m0 drops.
        repeat (8) drive(1'b1, 16'h0001, 1'b1, 16'h0002, 1'b1);
        drive(1'b0, 16'h0001, 1'b1, 16'h0002, 1'b1);
        idle(2);
        // m1 streams 0x0100..0x0107 back to back.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 16'h0100 + 16'(i), 1'b1);
        end
        idle(3);
        // Reset the cycle after an m0 issue, then contend.
        drive(1'b1, 16'h0010, 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        repeat (2) drive(1'b1, 16'h0001, 1'b1, 16'h0002, 1'b1);
        idle(3);
        // m1 withdraws while m0 is granted.
        drive(1'b1, 16'h0003, 1'b1, 16'h0004, 1'b1);
        drive(1'b1, 16'h0005, 1'b0, 16'h0004, 1'b1);
        idle(3);
        // Randomised traffic with occasional resets.
        repeat (600) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom),
                  1'($urandom_range(0, 1)), AW'($urandom),
                  1'($urandom_range(0, 59) != 0));
        end
        idle(4);
        @(negedge clk);
        #1;
        check("rsp_drained", 0, 32'(rspq.size()), 32'd0);
        check("ack_drained", 0, 32'(ackq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, the ROM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the ROM data width.
REQ-003 SHALL have parameter ROUND_ROBIN, default 1; 1 selects round-robin arbitration, 0 selects fixed priority with m0 highest.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port m0_req, input, 1, requester 0 read request; held with address stable until acknowledged.
REQ-007 SHALL have port m0_addr, input, ADDR_WIDTH, requester 0 read address.
REQ-008 SHALL have port m0_ack, output, 1, combinational; high in the cycle requester 0's read is issued to the ROM.
REQ-009 SHALL have port m0_rvalid, output, 1, registered one-cycle pulse marking m0_rdata updated.
REQ-010 SHALL have port m0_rdata, output, DATA_WIDTH, registered read data for requester 0; holds until its next response.
REQ-011 SHALL have ports m1_req, m1_addr, m1_ack, m1_rvalid and m1_rdata, identical to REQ-006..REQ-010, for requester 1.
REQ-012 SHALL have port rom_cs, output, 1, combinational ROM chip select.
REQ-013 SHALL have port rom_addr, output, ADDR_WIDTH, combinational ROM address; equals the granted requester's address, else all zeros.
REQ-014 SHALL have port rom_data, input, DATA_WIDTH, ROM read data; valid the cycle after rom_cs was high.

Function
REQ-015 SHALL issue at most one read per cycle: rom_cs = m0_ack | m1_ack, and m0_ack and m1_ack are never high together.
REQ-016 SHALL grant a lone requesting master in the same cycle its req is high; no idle gap when only one master requests.
REQ-017 SHALL, with both requesting and ROUND_ROBIN=1, grant the master not granted most recently; the last-grant pointer updates only on a grant.
REQ-018 SHALL, with both requesting and ROUND_ROBIN=0, always grant m0.
REQ-019 SHALL keep a two-stage in-flight pipeline: stage 1 is valid plus owner ID and is set on the issue edge; stage 2 captures rom_data into the owner's rdata register one edge later.
REQ-020 SHALL give a fixed latency: issue in cycle N, rdata updated and rvalid high in cycle N+2 for exactly one cycle.
REQ-021 SHALL sustain back-to-back issues every cycle, with responses returned in issue order with correct owner tagging, including alternating owners.
REQ-022 SHALL leave the non-owner's rdata unchanged and its rvalid low on every response.
REQ-023 SHALL treat a req dropped before ack as withdrawn: no read is issued and the pointer is not updated.
REQ-024 SHALL not assert rvalid for any request issued before a reset; a mid-flight read is discarded.

Reset
REQ-025 SHALL, while rst_n is low, force the pipeline valid bits, m0_rvalid and m1_rvalid to 0, m0_rdata and m1_rdata to 0, and the last-grant pointer to "m1", so m0 wins the first contention.
REQ-026 SHALL, while rst_n is low, hold m0_ack, m1_ack and rom_cs at 0 regardless of req.
REQ-027 SHALL honour requests from the first rising clk edge after rst_n deasserts.

Structure
REQ-028 SHALL place the owner-ID encoding (M0=0, M1=1) and the latency constant (2) in a shared package used by rom_arbiter and its bench.
REQ-029 SHALL be a single module; arbitration is inline with no sub-module, and the ROM is instantiated outside the block.

Verification
REQ-030 SHALL pass a solo read test: ROM preloaded so word 0x0010 = 0xA5; m0_req with addr 0x0010 -> m0_ack in the same cycle, m0_rvalid two cycles later with m0_rdata = 0xA5, and m1_rvalid stays 0.
REQ-031 SHALL pass a contention test: after reset, both masters request continuously with m0 at 0x0001 and m1 at 0x0002 -> grants m0, m1, m0, m1 ..., with rvalid/rdata alternating and matching each address.
REQ-032 SHALL pass a fixed-priority test: ROUND_ROBIN=0 with both requesting for 4 cycles -> m0_ack high on all 4 cycles, m1_ack 0, and m1 granted on the cycle m0_req drops.
REQ-033 SHALL pass a back-to-back test: m1 streams addrs 0x0100..0x0107 one per cycle -> 8 consecutive m1_rvalid pulses with data in address order.
REQ-034 SHALL pass a reset-mid-flight test: rst_n low for one cycle the cycle after an m0 issue -> no m0_rvalid, m0_rdata = 0, and the pointer favours m0 on the next contention.
REQ-035 SHALL pass a withdrawal test: m1_req drops in the same cycle m0 is granted -> no m1 read issued and no m1_rvalid.
